// File: rtl/multicycle_pkg.sv
// Shared encodings for the RV32I-subset multicycle control unit: FSM states,
// opcodes, ALU operation codes and the decoded-instruction payload.
package multicycle_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned ALU_W   = 4;

    localparam logic [STATE_W-1:0] ST_IF   = 3'd0;
    localparam logic [STATE_W-1:0] ST_ID   = 3'd1;
    localparam logic [STATE_W-1:0] ST_EX   = 3'd2;
    localparam logic [STATE_W-1:0] ST_MEM  = 3'd3;
    localparam logic [STATE_W-1:0] ST_WB   = 3'd4;
    localparam logic [STATE_W-1:0] ST_TRAP = 3'd5;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_RR  = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_SRL = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_SLL = 4'b1001;
    localparam logic [ALU_W-1:0] ALU_SRA = 4'b1010;
    localparam logic [ALU_W-1:0] ALU_XOR = 4'b1101;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_I   = 3'd1,
        CLS_LW  = 3'd2,
        CLS_SW  = 3'd3,
        CLS_BEQ = 3'd4
    } instr_class_e;

    typedef struct packed {
        instr_class_e     cls;
        logic [ALU_W-1:0] alu_ctrl;
        logic             alu_src;
        logic             illegal;
    } decode_t;

    // funct3 -> ALU op for register and immediate arithmetic; alt selects SUB/SRA
    function automatic logic [ALU_W-1:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        logic [ALU_W-1:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLT;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mc_decoder.sv
// Combinational instruction decoder: instr -> {class, ALU op, ALU source, illegal}.
module mc_decoder
    import multicycle_pkg::*;
(
    input  logic [31:0] instr_i,
    output decode_t     dec_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr_bits;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign unused_instr_bits = ^{instr_i[24:15], instr_i[11:7]};

    always_comb begin
        dec_o = '0;
        case (opcode)
            OP_RR: begin
                dec_o.cls = CLS_R;
                if (funct7 == F7_BASE) begin
                    dec_o.alu_ctrl = alu_from_f3(funct3, 1'b0);
                end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    dec_o.alu_ctrl = alu_from_f3(funct3, 1'b1);
                end else begin
                    dec_o.illegal = 1'b1;
                end
            end
            OP_IMM: begin
                dec_o.cls     = CLS_I;
                dec_o.alu_src = 1'b1;
                // only the shift-immediates constrain funct7
                if (funct3 == 3'b001) begin
                    dec_o.alu_ctrl = ALU_SLL;
                    dec_o.illegal  = (funct7 != F7_BASE);
                end else if (funct3 == 3'b101) begin
                    dec_o.alu_ctrl = alu_from_f3(funct3, funct7 == F7_ALT);
                    dec_o.illegal  = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                end else begin
                    dec_o.alu_ctrl = alu_from_f3(funct3, 1'b0);
                end
            end
            OP_LW: begin
                dec_o.cls      = CLS_LW;
                dec_o.alu_src  = 1'b1;
                dec_o.alu_ctrl = ALU_ADD;
                dec_o.illegal  = (funct3 != 3'b010);
            end
            OP_SW: begin
                dec_o.cls      = CLS_SW;
                dec_o.alu_src  = 1'b1;
                dec_o.alu_ctrl = ALU_ADD;
                dec_o.illegal  = (funct3 != 3'b010);
            end
            OP_BEQ: begin
                dec_o.cls      = CLS_BEQ;
                dec_o.alu_ctrl = ALU_SUB;
                dec_o.illegal  = (funct3 != 3'b000);
            end
            default: dec_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM (IF/ID/EX/MEM/WB/TRAP) with memory ready handshakes,
// wait timeout, illegal-instruction trap and cycle/instret counters.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int unsigned CNT_W         = 32,
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned WAIT_TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic              zero,
    input  logic              imem_ready,
    input  logic              dmem_ready,
    output logic              ir_write,
    output logic              ALUSrc,
    output logic [ALU_W-1:0]  ALUCtrl,
    output logic              RegWrite,
    output logic              MemToReg,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              loadPC,
    output logic              PCSrc,
    output logic              retire,
    output logic              trap,
    output logic [STATE_W-1:0] state_o,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instret_cnt
);

    localparam int unsigned WAIT_W = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        (WAIT_TIMEOUT == 0) ? '0 : WAIT_W'(WAIT_TIMEOUT - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   cycle_q, instret_q;
    decode_t            dec, dec_q;
    logic               imem_rdy, dmem_rdy, wait_hit;

    mc_decoder u_decoder (
        .instr_i (instr),
        .dec_o   (dec)
    );

    assign imem_rdy = MEM_HANDSHAKE ? imem_ready : 1'b1;
    assign dmem_rdy = MEM_HANDSHAKE ? dmem_ready : 1'b1;
    // current wait cycle is the last one allowed before giving up
    assign wait_hit = (WAIT_TIMEOUT != 0) && (wait_q == WAIT_LAST);

    always_comb begin
        state_d  = state_q;
        wait_d   = '0;
        ir_write = 1'b0;
        ALUSrc   = 1'b0;
        ALUCtrl  = '0;
        RegWrite = 1'b0;
        MemToReg = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        loadPC   = 1'b0;
        PCSrc    = 1'b0;
        retire   = 1'b0;

        case (state_q)
            ST_IF: begin
                ir_write = imem_rdy & ~rst;
                if (imem_rdy)      state_d = ST_ID;
                else if (wait_hit) state_d = ST_TRAP;
            end
            ST_ID: state_d = dec.illegal ? ST_TRAP : ST_EX;
            ST_EX: begin
                ALUSrc  = dec_q.alu_src;
                ALUCtrl = dec_q.alu_ctrl;
                case (dec_q.cls)
                    CLS_BEQ: begin
                        loadPC  = 1'b1;
                        PCSrc   = zero;
                        retire  = 1'b1;
                        state_d = ST_IF;
                    end
                    CLS_LW, CLS_SW: state_d = ST_MEM;
                    default:        state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                ALUSrc   = dec_q.alu_src;
                ALUCtrl  = dec_q.alu_ctrl;
                MemRead  = (dec_q.cls == CLS_LW);
                MemWrite = (dec_q.cls == CLS_SW);
                if (dmem_rdy) begin
                    if (dec_q.cls == CLS_LW) begin
                        state_d = ST_WB;
                    end else begin
                        loadPC  = 1'b1;
                        retire  = 1'b1;
                        state_d = ST_IF;
                    end
                end else if (wait_hit) begin
                    state_d = ST_TRAP;
                end
            end
            ST_WB: begin
                ALUSrc   = dec_q.alu_src;
                ALUCtrl  = dec_q.alu_ctrl;
                RegWrite = 1'b1;
                MemToReg = (dec_q.cls == CLS_LW);
                loadPC   = 1'b1;
                retire   = 1'b1;
                state_d  = ST_IF;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_TRAP;
        endcase

        // wait counter only runs while stalled in IF or MEM
        if (state_d == state_q && (state_q == ST_IF || state_q == ST_MEM)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IF;
            wait_q    <= '0;
            dec_q     <= '0;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == ST_ID) dec_q <= dec;
            cycle_q <= cycle_q + CNT_W'(1);
            if (retire) instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign trap        = (state_q == ST_TRAP);
    assign state_o     = state_q;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: a per-cycle expected trace is built from
// instruction-level rules and replayed against the DUT.
module tb_multicycle_ctrl;

    localparam int unsigned CNT_W = 32;
    localparam int          WT    = 16;
    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic        ir_write, ALUSrc, RegWrite, MemToReg, MemRead, MemWrite;
    logic        loadPC, PCSrc, retire, trap;
    logic [3:0]  ALUCtrl;
    logic [2:0]  state_o;
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;

    multicycle_ctrl #(
        .CNT_W         (CNT_W),
        .MEM_HANDSHAKE (1'b1),
        .WAIT_TIMEOUT  (WT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .zero        (zero),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .ir_write    (ir_write),
        .ALUSrc      (ALUSrc),
        .ALUCtrl     (ALUCtrl),
        .RegWrite    (RegWrite),
        .MemToReg    (MemToReg),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .loadPC      (loadPC),
        .PCSrc       (PCSrc),
        .retire      (retire),
        .trap        (trap),
        .state_o     (state_o),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [31:0] instr;
        bit          zero, imem_r, dmem_r;
        logic [2:0]  st;
        bit          ir_write, alu_src, reg_write, mem_to_reg, mem_read, mem_write;
        bit          load_pc, pc_src, retire, trap;
        logic [3:0]  alu;
    } cyc_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         f7_any;
        logic [3:0] alu;
        int         kind;
    } ent_t;

    cyc_t q[$];
    ent_t tbl[20];
    int   n_checks = 0;
    int   n_err    = 0;
    logic [CNT_W-1:0] exp_cyc = '0, exp_ret = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic cyc_t blank(input logic [2:0] st);
        cyc_t r;
        r.rst = 1'b0;
        r.instr = $urandom;
        r.zero = 1'($urandom_range(0, 1));
        r.imem_r = 1'($urandom_range(0, 1));
        r.dmem_r = 1'($urandom_range(0, 1));
        r.st = st;
        r.ir_write = 0; r.alu_src = 0; r.reg_write = 0; r.mem_to_reg = 0;
        r.mem_read = 0; r.mem_write = 0; r.load_pc = 0; r.pc_src = 0; r.retire = 0;
        r.trap = (st == 3'd5);
        r.alu = '0;
        return r;
    endfunction

    // a few cycles parked in TRAP, reset asserted on the last of them
    task automatic trap_then_reset();
        cyc_t r;
        for (int i = 0; i < 4; i++) begin
            r = blank(3'd5);
            r.rst = (i == 3);
            q.push_back(r);
        end
    endtask

    // expected per-cycle trace of one instruction from the instruction-level rules
    task automatic gen(input logic [31:0] w, input int kind, input logic [3:0] alu,
                       input bit ill, input int idly, input int ddly, input int zmode,
                       input int rst_mem);
        cyc_t r;
        bit   src;
        int   n;
        src = (kind == K_I) || (kind == K_LW) || (kind == K_SW);
        n = (idly >= WT) ? WT : idly;
        for (int i = 0; i < n; i++) begin
            r = blank(3'd0);
            r.imem_r = 1'b0;
            q.push_back(r);
        end
        if (idly >= WT) begin trap_then_reset(); return; end
        r = blank(3'd0); r.imem_r = 1'b1; r.ir_write = 1'b1; r.instr = w; q.push_back(r);
        r = blank(3'd1); r.instr = w; q.push_back(r);
        if (ill) begin trap_then_reset(); return; end
        r = blank(3'd2); r.alu = alu; r.alu_src = src;
        if (zmode < 2) r.zero = (zmode == 1);
        if (kind == K_BEQ) begin
            r.load_pc = 1'b1; r.pc_src = r.zero; r.retire = 1'b1;
            q.push_back(r);
            return;
        end
        q.push_back(r);
        if (kind == K_LW || kind == K_SW) begin
            n = (ddly >= WT) ? WT : ddly;
            for (int i = 0; i < n; i++) begin
                r = blank(3'd3); r.alu = alu; r.alu_src = src; r.dmem_r = 1'b0;
                r.mem_read = (kind == K_LW); r.mem_write = (kind == K_SW);
                r.rst = (rst_mem != 0) && (i == rst_mem - 1);
                q.push_back(r);
                if (r.rst) return;
            end
            if (ddly >= WT) begin trap_then_reset(); return; end
            r = blank(3'd3); r.alu = alu; r.alu_src = src; r.dmem_r = 1'b1;
            r.mem_read = (kind == K_LW); r.mem_write = (kind == K_SW);
            if (kind == K_SW) begin
                r.load_pc = 1'b1; r.retire = 1'b1;
                q.push_back(r);
                return;
            end
            q.push_back(r);
        end
        r = blank(3'd4); r.alu = alu; r.alu_src = src; r.reg_write = 1'b1;
        r.mem_to_reg = (kind == K_LW); r.load_pc = 1'b1; r.retire = 1'b1;
        q.push_back(r);
    endtask

    task automatic mk_illegal(output logic [31:0] w);
        logic [6:0] op, f7;
        logic [2:0] f3;
        w = $urandom;
        case ($urandom_range(0, 5))
            0: begin
                do op = 7'($urandom); while (op inside {7'h03, 7'h23, 7'h63, 7'h13, 7'h33});
                w[6:0] = op;
            end
            1: begin
                do f7 = 7'($urandom); while (f7 inside {7'h00, 7'h20});
                w[6:0] = 7'h33; w[31:25] = f7;
            end
            2: begin
                do f3 = 3'($urandom); while (f3 inside {3'd0, 3'd5});
                w[6:0] = 7'h33; w[14:12] = f3; w[31:25] = 7'h20;
            end
            3: begin
                do f7 = 7'($urandom); while (f7 inside {7'h00, 7'h20});
                w[6:0] = 7'h13; w[14:12] = ($urandom_range(0, 1) == 1) ? 3'd1 : 3'd5;
                w[31:25] = f7;
            end
            4: begin
                do f3 = 3'($urandom); while (f3 == 3'd2);
                w[6:0] = ($urandom_range(0, 1) == 1) ? 7'h03 : 7'h23; w[14:12] = f3;
            end
            default: begin
                do f3 = 3'($urandom); while (f3 == 3'd0);
                w[6:0] = 7'h63; w[14:12] = f3;
            end
        endcase
    endtask

    task automatic run_queue();
        cyc_t r;
        while (q.size() != 0) begin
            r = q.pop_front();
            @(posedge clk);
            #1;
            rst = r.rst; instr = r.instr; zero = r.zero;
            imem_ready = r.imem_r; dmem_ready = r.dmem_r;
            @(negedge clk);
            check("state", 64'(state_o), 64'(r.st));
            check("strobes",
                  64'({ir_write, ALUSrc, ALUCtrl, RegWrite, MemToReg, MemRead, MemWrite,
                       loadPC, PCSrc, retire, trap}),
                  64'({r.ir_write, r.alu_src, r.alu, r.reg_write, r.mem_to_reg, r.mem_read,
                       r.mem_write, r.load_pc, r.pc_src, r.retire, r.trap}));
            check("cycle_cnt", 64'(cycle_cnt), 64'(exp_cyc));
            check("instret_cnt", 64'(instret_cnt), 64'(exp_ret));
            if (r.rst) begin
                exp_cyc = '0;
                exp_ret = '0;
            end else begin
                exp_cyc = exp_cyc + CNT_W'(1);
                exp_ret = exp_ret + CNT_W'(r.retire);
            end
        end
    endtask

    initial begin
        cyc_t r;
        ent_t e;
        logic [31:0] w;
        int id, dd;

        tbl[0]  = '{7'h33, 3'd0, 7'h00, 1'b0, 4'b0010, K_R};
        tbl[1]  = '{7'h33, 3'd0, 7'h20, 1'b0, 4'b0110, K_R};
        tbl[2]  = '{7'h33, 3'd1, 7'h00, 1'b0, 4'b1001, K_R};
        tbl[3]  = '{7'h33, 3'd2, 7'h00, 1'b0, 4'b0111, K_R};
        tbl[4]  = '{7'h33, 3'd4, 7'h00, 1'b0, 4'b1101, K_R};
        tbl[5]  = '{7'h33, 3'd5, 7'h00, 1'b0, 4'b1000, K_R};
        tbl[6]  = '{7'h33, 3'd5, 7'h20, 1'b0, 4'b1010, K_R};
        tbl[7]  = '{7'h33, 3'd6, 7'h00, 1'b0, 4'b0001, K_R};
        tbl[8]  = '{7'h33, 3'd7, 7'h00, 1'b0, 4'b0000, K_R};
        tbl[9]  = '{7'h13, 3'd0, 7'h00, 1'b1, 4'b0010, K_I};
        tbl[10] = '{7'h13, 3'd2, 7'h00, 1'b1, 4'b0111, K_I};
        tbl[11] = '{7'h13, 3'd4, 7'h00, 1'b1, 4'b1101, K_I};
        tbl[12] = '{7'h13, 3'd6, 7'h00, 1'b1, 4'b0001, K_I};
        tbl[13] = '{7'h13, 3'd7, 7'h00, 1'b1, 4'b0000, K_I};
        tbl[14] = '{7'h13, 3'd1, 7'h00, 1'b0, 4'b1001, K_I};
        tbl[15] = '{7'h13, 3'd5, 7'h00, 1'b0, 4'b1000, K_I};
        tbl[16] = '{7'h13, 3'd5, 7'h20, 1'b0, 4'b1010, K_I};
        tbl[17] = '{7'h03, 3'd2, 7'h00, 1'b1, 4'b0010, K_LW};
        tbl[18] = '{7'h23, 3'd2, 7'h00, 1'b1, 4'b0010, K_SW};
        tbl[19] = '{7'h63, 3'd0, 7'h00, 1'b1, 4'b0110, K_BEQ};

        repeat (2) @(posedge clk);

        // reset cycle: IF, counters zero, no strobes even with imem_ready high
        r = blank(3'd0); r.rst = 1'b1; r.imem_r = 1'b1; q.push_back(r);

        gen(32'h00500093, K_I,   4'b0010, 1'b0, 0, 0, 2, 0);
        gen(32'h402081B3, K_R,   4'b0110, 1'b0, 0, 0, 2, 0);
        gen(32'h4020D093, K_I,   4'b1010, 1'b0, 0, 0, 2, 0);
        gen(32'h00000463, K_BEQ, 4'b0110, 1'b0, 0, 0, 1, 0);
        gen(32'h00000463, K_BEQ, 4'b0110, 1'b0, 0, 0, 0, 0);
        gen(32'h00002283, K_LW,  4'b0010, 1'b0, 0, 3, 2, 0);
        gen(32'h00502223, K_SW,  4'b0010, 1'b0, 0, 20, 2, 0);
        gen(32'h00000000, K_R,   4'b0000, 1'b1, 0, 0, 2, 0);
        gen(32'h02208033, K_R,   4'b0000, 1'b1, 0, 0, 2, 0);
        gen(32'h00502223, K_SW,  4'b0010, 1'b0, 1, 20, 2, 3);
        gen(32'h00500093, K_I,   4'b0010, 1'b0, 15, 0, 2, 0);
        gen(32'h00500093, K_I,   4'b0010, 1'b0, 16, 0, 2, 0);
        gen(32'h00002283, K_LW,  4'b0010, 1'b0, 0, 15, 2, 0);
        gen(32'h00502223, K_SW,  4'b0010, 1'b0, 2, 0, 2, 0);
        gen(32'h00002283, K_LW,  4'b0010, 1'b0, 0, 16, 2, 0);

        for (int k = 0; k < 80; k++) begin
            id = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 2);
            dd = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) begin
                mk_illegal(w);
                gen(w, K_R, 4'b0000, 1'b1, id, 0, 2, 0);
            end else begin
                e = tbl[$urandom_range(0, 19)];
                w = $urandom;
                w[6:0] = e.op;
                w[14:12] = e.f3;
                if (!e.f7_any) w[31:25] = e.f7;
                gen(w, e.kind, e.alu, 1'b0, id, dd, 2, 0);
            end
        end

        run_queue();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Explicit-state multicycle control unit for the RV32I subset LW, SW, BEQ, I-type ALU and R-type ALU.
- Drives the existing datapath strobes (ALUSrc, ALUCtrl, RegWrite, MemToReg, loadPC, PCSrc) and the data-memory strobes (MemRead, MemWrite).
- Adds ready handshakes to instruction and data memory, a memory-wait timeout and an illegal-instruction trap.
- Provides cycle and retired-instruction counters. Sits between the instruction/data memories and the datapath in the multicycle top.

Parameters:
- CNT_W, 32, width of cycle_cnt and instret_cnt.
- MEM_HANDSHAKE, 1, 1 = honour imem_ready/dmem_ready; 0 = both readies treated as constant 1.
- WAIT_TIMEOUT, 16, maximum wait cycles in IF or MEM before TRAP. 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  instruction word from instruction memory.
- zero  in  1  ALU zero flag from the datapath.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data access completes this cycle.
- ir_write  out  1  latch instr into the instruction register.
- ALUSrc  out  1  0 = rs2, 1 = immediate.
- ALUCtrl  out  4  ALU operation code.
- RegWrite  out  1  register file write enable.
- MemToReg  out  1  write-back source: 1 = memory, 0 = ALU.
- MemRead  out  1  data memory read strobe.
- MemWrite  out  1  data memory write strobe.
- loadPC  out  1  PC update enable.
- PCSrc  out  1  0 = PC+4, 1 = branch target.
- retire  out  1  one-cycle pulse when an instruction completes.
- trap  out  1  sticky error flag.
- state_o  out  3  current state, for debug.
- cycle_cnt  out  CNT_W  cycles since reset.
- instret_cnt  out  CNT_W  retired instructions since reset.

Behaviour:
- Reset (rst=1 at a clk edge): state=IF, wait counter=0, both counters=0, trap=0, decode registers=0. All strobes are 0 during and after reset until driven by a state.
- States and encodings: IF=0, ID=1, EX=2, MEM=3, WB=4, TRAP=5. Outputs are Moore, from state plus registered decode, except PCSrc, which is taken from zero in EX.
- IF:
  - ir_write = imem_ready.
  - When ready, go to ID. Otherwise stay and increment the wait counter.
  - Wait counter reaching WAIT_TIMEOUT goes to TRAP.
- ID:
  - Decode instr into registered class, ALUCtrl, ALUSrc and illegal.
  - illegal -> TRAP; otherwise -> EX.
- ALUCtrl encoding: ADD/ADDI/LW/SW=0010, SUB/BEQ=0110, AND=0000, OR=0001, XOR=1101, SLT=0111, SLL=1001, SRL=1000, SRA=1010.
- Illegal instructions:
  - Any other opcode.
  - R-type funct7 not 0000000/0100000.
  - funct7=0100000 with funct3 not 000 or 101.
  - SLLI/SRLI/SRAI with an invalid funct7.
  - LW funct3≠010, SW funct3≠010, BEQ funct3≠000.
- ALUSrc: 1 for LW, SW and I-type; 0 otherwise.
- EX: ALUCtrl/ALUSrc are driven from ID and held stable through WB.
  - BEQ: loadPC=1, PCSrc=zero, retire=1 -> IF.
  - LW/SW -> MEM. R/I-type -> WB.
- MEM:
  - LW holds MemRead=1; SW holds MemWrite=1, until dmem_ready.
  - On ready: SW gives loadPC=1, retire=1 -> IF. LW -> WB.
  - Timeout goes to TRAP with strobes dropped.
- WB: RegWrite=1, MemToReg=(class==LW), loadPC=1, PCSrc=0, retire=1 -> IF.
- Wait counter clears on every state change.
- loadPC and retire pulse exactly once per retired instruction. RegWrite pulses only in WB. MemRead and MemWrite are never both 1.
- TRAP: trap=1, all strobes 0, cycle_cnt keeps counting, instret_cnt frozen. Exit only by rst.
- Counters:
  - cycle_cnt increments every non-reset cycle.
  - instret_cnt increments on retire.
  - Both wrap modulo 2^CNT_W with no flag.
- Reset asserted mid-instruction (any state, including MEM with MemWrite=1) takes effect at that edge; strobes are 0 in the following cycle.
- Cycle counts with readies held at 1: BEQ 3, SW 4, R/I 4, LW 5.

Decomposition:
- multicycle_pkg: state encodings, opcode constants (LW=0000011, SW=0100011, BEQ=1100011, IMM=0010011, RR=0110011), ALU codes, instruction-class enum.
- Sub-module mc_decoder: purely combinational. Maps instr to {class, ALUCtrl, ALUSrc, illegal}; instantiated once, output registered in ID.

Test Plan:
- addi x1,x0,5 (0x00500093), readies=1 -> states IF,ID,EX,WB. ALUCtrl=0010 and ALUSrc=1 from EX. RegWrite=1, loadPC=1, retire=1 in cycle 4 only. instret_cnt=1.
- sub x3,x1,x2 (0x402081B3) -> ALUCtrl=0110, ALUSrc=0, 4 cycles. Then srai x1,x1,2 (0x4020D093) -> ALUCtrl=1010.
- beq x0,x0,8 (0x00000463) with zero=1 -> PCSrc=1, loadPC=1 in EX (cycle 3). Repeat with zero=0 -> PCSrc=0, loadPC=1. No RegWrite in either run.
- lw x5,0(x0) (0x00002283) with dmem_ready low 3 cycles -> MemRead held 4 cycles, then WB with MemToReg=1, RegWrite=1. Total 8 cycles.
- sw x5,4(x0) (0x00502223), dmem_ready low 20 cycles, WAIT_TIMEOUT=16 -> TRAP after 16 wait cycles. MemWrite drops, trap=1, instret frozen, cycle_cnt keeps counting. rst -> state IF, trap=0.
- instr=0x00000000 -> TRAP from ID. R-type funct7=0000001 -> TRAP. rst asserted during MEM of SW -> MemWrite=0 and state IF next cycle.
